// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg : shared segment glyph table and sizing helper for the           |
// |            seven-segment scan driver                                      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
package seg7_pkg;

   // Segment bus order is {g,f,e,d,c,b,a}; patterns are active-low (0 = lit).
   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_hex_decode : combinational 0-F nibble to active-low segment decode   |
// | Revision        : 1.0                                                     |
// +----------------------------------------------------------------------------+
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_n_o
);

   assign seg_n_o = SEG_TABLE[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver : time-multiplexed N-digit seven-segment driver with     |
// |                    hex decode, polarity control and inter-digit blanking. |
// |                    Define SEG7_LZ_SUPPRESS_EN for leading-zero blanking.  |
// | Revision         : 1.0                                                    |
// +----------------------------------------------------------------------------+
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter  int NUM_DIGITS     = 4,
   parameter  int SCAN_DIV       = 50000,
   parameter  int BLANK_CYC      = 500,
   parameter  int SEG_ACTIVE_LOW = 1,
   parameter  int AN_ACTIVE_LOW  = 1,
   localparam int IDX_W          = cnt_width(NUM_DIGITS)
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   input  logic [4*NUM_DIGITS-1:0] iData,
   input  logic                    iLoad,
   input  logic                    iInit,
   output logic [6:0]              oSeg,
   output logic [NUM_DIGITS-1:0]   oAn,
   output logic [IDX_W-1:0]        oDigitIdx
);

   localparam int                    PRE_W    = cnt_width(SCAN_DIV);
   localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic [PRE_W-1:0]        pre_q, pre_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [IDX_W-1:0]        didx_q;

   logic                    w_pre_wrap;
   logic [3:0]              w_nibble;
   logic [6:0]              w_seg_n;
   logic [6:0]              w_seg_al;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic                    w_lz_blank;

   assign w_nibble = data_q[4*idx_q +: 4];

   seg7_hex_decode u_dec (
      .nibble_i (w_nibble),
      .seg_n_o  (w_seg_n)
   );

`ifdef SEG7_LZ_SUPPRESS_EN
   // Blank a non-zero position when it and every digit above it hold zero.
   always_comb begin
      w_lz_blank = (idx_q != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((IDX_W'(k) >= idx_q) && (data_q[4*k +: 4] != 4'h0)) begin
            w_lz_blank = 1'b0;
         end
      end
   end
`else
   assign w_lz_blank = 1'b0;
`endif

   always_comb begin
      data_d     = iLoad ? iData : data_q;
      w_pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
      pre_d      = w_pre_wrap ? '0 : pre_q + 1'b1;
      idx_d      = idx_q;
      if (w_pre_wrap) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      w_onehot        = '0;
      w_onehot[idx_q] = 1'b1;
      w_seg_al        = w_lz_blank ? SEG_OFF : w_seg_n;

      seg_d = SEG_IDLE;
      an_d  = AN_IDLE;
      if (!iInit) begin
         seg_d = (SEG_ACTIVE_LOW != 0) ? w_seg_al : ~w_seg_al;
         if (pre_q >= PRE_W'(BLANK_CYC)) begin
            an_d = (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
         end
      end
   end

   // Segments and anodes share one edge so a digit never sees its neighbour's glyph.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         data_q <= '0;
         pre_q  <= '0;
         idx_q  <= '0;
         seg_q  <= SEG_IDLE;
         an_q   <= AN_IDLE;
         didx_q <= '0;
      end else begin
         data_q <= data_d;
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
         didx_q <= idx_q;
      end
   end

   assign oSeg      = seg_q;
   assign oAn       = an_q;
   assign oDigitIdx = didx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_driver : randomized bench for seg7_scan_driver against a     |
// |                       cycle-count reference model (4 digits, div 8)       |
// | Revision            : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic        init;
   logic [15:0] data;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [1:0]  idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS     (N),
      .SCAN_DIV       (DIV),
      .BLANK_CYC      (BLANK),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .iClk      (clk),
      .iRst_n    (rst_n),
      .iData     (data),
      .iLoad     (load),
      .iInit     (init),
      .oSeg      (seg),
      .oAn       (an),
      .oDigitIdx (idx)
   );

   // Reference model: slot position derived purely from edges since reset.
   int          edges;
   logic [3:0]  mdata [N];
   logic [6:0]  exp_seg;
   logic [3:0]  exp_an;
   logic [1:0]  exp_idx;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [6:0] shown(input int d);
      logic [6:0] g;
      int         msd;
      g   = glyph(mdata[d]);
      msd = 0;
      for (int k = 0; k < N; k++) if (mdata[k] != 4'h0) msd = k;
`ifdef SEG7_LZ_SUPPRESS_EN
      if (d > msd) g = 7'h7F;
`endif
      return g;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edges   <= 0;
         exp_seg <= 7'h7F;
         exp_an  <= 4'hF;
         exp_idx <= 2'd0;
         for (int k = 0; k < N; k++) mdata[k] <= 4'h0;
      end else begin
         exp_seg <= init ? 7'h7F : shown((edges / DIV) % N);
         exp_an  <= (init || ((edges % DIV) < BLANK)) ? 4'hF
                    : ~(4'b0001 << ((edges / DIV) % N));
         exp_idx <= 2'((edges / DIV) % N);
         if (load) for (int k = 0; k < N; k++) mdata[k] <= data[4*k +: 4];
         edges   <= edges + 1;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b0; init = 1'b0; data = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want %b", seg, 7'h7F); end
      checks++;
      if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want %b", an, 4'hF); end
      checks++;
      if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx); end
      rst_n = 1'b1;
      for (int c = 0; c < 3 * DIV; c++) begin
         @(negedge clk);
         checks++;
         if (seg !== exp_seg || an !== exp_an || idx !== exp_idx) begin
            errors++;
            $display("FAIL post_reset c=%0d got seg=%b an=%b idx=%0d want seg=%b an=%b idx=%0d",
                     c, seg, an, idx, exp_seg, exp_an, exp_idx);
         end
      end
   endtask

   task automatic test_load(input logic [15:0] value, input int cycles);
      data = value; load = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         load = 1'b0;
         checks++;
         if (seg !== exp_seg || an !== exp_an || idx !== exp_idx) begin
            errors++;
            $display("FAIL load_%h c=%0d got seg=%b an=%b idx=%0d want seg=%b an=%b idx=%0d",
                     value, c, seg, an, idx, exp_seg, exp_an, exp_idx);
         end
      end
   endtask

   task automatic test_init();
      init = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         load = 1'b0;
         checks++;
         if (seg !== 7'h7F || an !== 4'hF || idx !== exp_idx) begin
            errors++;
            $display("FAIL init_hold c=%0d got seg=%b an=%b idx=%0d want seg=1111111 an=1111 idx=%0d",
                     c, seg, an, idx, exp_idx);
         end
         if (c == 10) begin data = 16'($urandom); load = 1'b1; end
      end
      init = 1'b0;
      for (int c = 0; c < 2 * N * DIV; c++) begin
         @(negedge clk);
         checks++;
         if (seg !== exp_seg || an !== exp_an || idx !== exp_idx) begin
            errors++;
            $display("FAIL init_resume c=%0d got seg=%b an=%b idx=%0d want seg=%b an=%b idx=%0d",
                     c, seg, an, idx, exp_seg, exp_an, exp_idx);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         checks++;
         if (seg !== exp_seg || an !== exp_an || idx !== exp_idx) begin
            errors++;
            $display("FAIL random c=%0d got seg=%b an=%b idx=%0d want seg=%b an=%b idx=%0d",
                     c, seg, an, idx, exp_seg, exp_an, exp_idx);
         end
         load = ($urandom_range(0, 5) == 0);
         data = 16'($urandom);
         if ($urandom_range(0, 19) == 0) init = ~init;
      end
      load = 1'b0; init = 1'b0;
   endtask

   task automatic test_async_reset();
      int waited;
      waited = 0;
      while (!(exp_idx == 2'd2 && exp_an != 4'hF) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 100) begin
         errors++;
         $display("FAIL async_wait got timeout want digit 2 active");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (seg !== 7'h7F || an !== 4'hF || idx !== 2'd0) begin
         errors++;
         $display("FAIL async_reset got seg=%b an=%b idx=%0d want seg=1111111 an=1111 idx=0",
                  seg, an, idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < N * DIV + 4; c++) begin
         @(negedge clk);
         checks++;
         if (seg !== exp_seg || an !== exp_an || idx !== exp_idx) begin
            errors++;
            $display("FAIL async_restart c=%0d got seg=%b an=%b idx=%0d want seg=%b an=%b idx=%0d",
                     c, seg, an, idx, exp_seg, exp_an, exp_idx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load(16'h1234, 2 * N * DIV);
      test_load(16'hABCF, 2 * N * DIV);
      test_init();
      test_random();
      test_load(16'h9876, N * DIV);
      test_async_reset();
`ifdef SEG7_LZ_SUPPRESS_EN
      test_load(16'h0050, 2 * N * DIV);
      test_load(16'h0000, 2 * N * DIV);
`endif
      test_load(16'h0050, N * DIV);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
